branch_resolve: RTL and testbench

- Execute-stage branch/jump resolution unit. It sits directly downstream of the BranchComp comparator.
- Drives the comparator's BranchOp select, consumes its BrEq/BrLT flags, decides taken/not-taken for B-type, JAL and JALR, and computes the target.
- Issues a registered PC redirect to fetch, plus a multi-cycle flush of the younger pipeline stages through a small FSM.
- Keeps branch/taken event counters for performance monitoring.

---
 rtl/rv32i_pkg.sv | 26 ++
 rtl/branch_cond.sv | 27 ++
 rtl/branch_resolve.sv | 135 +++++++++++++
 tb/tb_branch_resolve.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode/funct3 constants and branch FSM state type
package rv32i_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_e;

  // BLTU/BGEU are the only funct3 codes that need an unsigned compare
  function automatic logic isUnsignedCmp(input logic [2:0] funct3);
    return funct3[2] & funct3[1];
  endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational B-type condition decode from comparator flags
module branch_cond
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       BrLT,
  output logic       taken,
  output logic       valid_f3,
  output logic       BranchOp
);

  assign BranchOp = isUnsignedCmp(funct3);

  always_comb begin
    taken    = 1'b0;
    valid_f3 = 1'b1;
    case (funct3)
      F3_BEQ:          taken = BrEq;
      F3_BNE:          taken = !BrEq;
      F3_BLT, F3_BLTU: taken = BrLT;
      F3_BGE, F3_BGEU: taken = !BrLT;
      default:         valid_f3 = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - EX-stage branch/jump resolution with registered redirect,
// multi-cycle flush FSM and branch/taken event counters
module branch_resolve
  import rv32i_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_stall,
  input  logic [6:0]            i_opcode,
  input  logic [2:0]            i_funct3,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic                  BrEq,
  input  logic                  BrLT,
  output logic                  BranchOp,
  output logic                  o_redirect,
  output logic [DATA_WIDTH-1:0] o_target,
  output logic                  o_flush,
  output logic                  o_misalign,
  output logic [CNT_WIDTH-1:0]  o_br_cnt,
  output logic [CNT_WIDTH-1:0]  o_taken_cnt
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] JALR_MASK = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  br_state_e             state;
  logic [2:0]            flushCnt;
  logic                  condTaken;
  logic                  condValid;
  logic                  isBranch;
  logic                  isJal;
  logic                  isJalr;
  logic                  resolve;
  logic                  brTaken;
  logic                  takeEvt;
  logic                  brCount;
  logic [DATA_WIDTH-1:0] pcTarget;
  logic [DATA_WIDTH-1:0] jalrTarget;
  logic [DATA_WIDTH-1:0] target;

  branch_cond uCond (
    .funct3   (i_funct3),
    .BrEq     (BrEq),
    .BrLT     (BrLT),
    .taken    (condTaken),
    .valid_f3 (condValid),
    .BranchOp (BranchOp)
  );

  assign isBranch = (i_opcode == OP_BRANCH);
  assign isJal    = (i_opcode == OP_JAL);
  assign isJalr   = (i_opcode == OP_JALR);
  assign resolve  = (state == IDLE) && i_valid && !i_stall;

  // isBranch gates the comparator flags so unknown flags on other opcodes stay masked
  assign brTaken  = isBranch && condValid && condTaken;
  assign takeEvt  = resolve && (brTaken || isJal || isJalr);
  assign brCount  = resolve && isBranch && condValid;

  assign pcTarget   = i_pc + i_imm;
  assign jalrTarget = (i_rs1_data + i_imm) & JALR_MASK;
  assign target     = isJalr ? jalrTarget : pcTarget;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      flushCnt    <= 3'd0;
      o_redirect  <= 1'b0;
      o_target    <= '0;
      o_flush     <= 1'b0;
      o_misalign  <= 1'b0;
      o_br_cnt    <= '0;
      o_taken_cnt <= '0;
    end else begin
      o_redirect <= 1'b0;
      o_misalign <= 1'b0;

      case (state)
        IDLE: begin
          if (takeEvt) begin
            if (target[1]) begin
              o_misalign <= 1'b1;
            end else begin
              state       <= REDIRECT;
              o_redirect  <= 1'b1;
              o_flush     <= 1'b1;
              o_target    <= target;
              o_taken_cnt <= o_taken_cnt + 1'b1;
            end
          end
        end

        REDIRECT: begin
          flushCnt <= FLUSH_RELOAD;
          if (FLUSH_CYCLES > 1) begin
            state <= FLUSH;
          end else begin
            state   <= IDLE;
            o_flush <= 1'b0;
          end
        end

        FLUSH: begin
          // a stalled pipeline keeps the same wrong-path contents, so hold the count
          if (!i_stall) begin
            if (flushCnt <= 3'd1) begin
              state    <= IDLE;
              o_flush  <= 1'b0;
              flushCnt <= 3'd0;
            end else begin
              flushCnt <= flushCnt - 3'd1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          o_flush <= 1'b0;
        end
      endcase

      if (brCount) begin
        o_br_cnt <= o_br_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - randomized self-checking bench for branch_resolve
module tb_branch_resolve;
  import rv32i_pkg::*;

  localparam int DW = 32;
  localparam int FC = 2;
  localparam int CW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic          i_stall;
  logic [6:0]    i_opcode;
  logic [2:0]    i_funct3;
  logic [DW-1:0] i_pc;
  logic [DW-1:0] i_imm;
  logic [DW-1:0] i_rs1_data;
  logic          BrEq;
  logic          BrLT;
  logic          BranchOp;
  logic          o_redirect;
  logic [DW-1:0] o_target;
  logic          o_flush;
  logic          o_misalign;
  logic [CW-1:0] o_br_cnt;
  logic [CW-1:0] o_taken_cnt;

  logic [DW-1:0] opA;
  logic [DW-1:0] opB;
  logic          forceX;

  int checks = 0;
  int errors = 0;

  logic          mRedir;
  logic          mFlush;
  logic          mMis;
  logic [DW-1:0] mTarget;
  logic [CW-1:0] mBr;
  logic [CW-1:0] mTaken;
  int            owed;

  branch_resolve #(.DATA_WIDTH(DW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_stall     (i_stall),
    .i_opcode    (i_opcode),
    .i_funct3    (i_funct3),
    .i_pc        (i_pc),
    .i_imm       (i_imm),
    .i_rs1_data  (i_rs1_data),
    .BrEq        (BrEq),
    .BrLT        (BrLT),
    .BranchOp    (BranchOp),
    .o_redirect  (o_redirect),
    .o_target    (o_target),
    .o_flush     (o_flush),
    .o_misalign  (o_misalign),
    .o_br_cnt    (o_br_cnt),
    .o_taken_cnt (o_taken_cnt)
  );

  always #5 i_clk = ~i_clk;

  // behavioural comparator driven by the DUT's BranchOp select
  always_comb begin
    if (forceX) begin
      BrEq = 1'bx;
      BrLT = 1'bx;
    end else begin
      BrEq = (opA == opB);
      BrLT = BranchOp ? (opA < opB) : ($signed(opA) < $signed(opB));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    check("redirect", 32'(o_redirect), 32'(mRedir));
    check("flush", 32'(o_flush), 32'(mFlush));
    check("misalign", 32'(o_misalign), 32'(mMis));
    check("target", o_target, mTarget);
    check("br_cnt", 32'(o_br_cnt), 32'(mBr));
    check("taken_cnt", 32'(o_taken_cnt), 32'(mTaken));
  endtask

  task automatic modelReset();
    mRedir = 0; mFlush = 0; mMis = 0; mTarget = '0; mBr = '0; mTaken = '0; owed = 0;
  endtask

  // one clock of stimulus; model follows the branch rules on the raw operands
  task automatic step(input logic v, input logic s, input logic [6:0] op, input logic [2:0] f3,
                      input logic [DW-1:0] pc, input logic [DW-1:0] imm, input logic [DW-1:0] rs1,
                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic take, cnt, nR, nM, nF;
    logic [DW-1:0] tgt;
    @(negedge i_clk);
    i_valid = v; i_stall = s; i_opcode = op; i_funct3 = f3;
    i_pc = pc; i_imm = imm; i_rs1_data = rs1; opA = a; opB = b;
    #1;
    check("branchop", 32'(BranchOp), 32'(f3 == 3'b110 || f3 == 3'b111));
    nR = 0; nM = 0; nF = mFlush;
    if (!mFlush) begin
      if (v && !s) begin
        take = 0; cnt = 0; tgt = pc + imm;
        if (op == OP_BRANCH) begin
          case (f3)
            3'd0: begin cnt = 1; take = (a == b); end
            3'd1: begin cnt = 1; take = (a != b); end
            3'd4: begin cnt = 1; take = ($signed(a) < $signed(b)); end
            3'd5: begin cnt = 1; take = ($signed(a) >= $signed(b)); end
            3'd6: begin cnt = 1; take = (a < b); end
            3'd7: begin cnt = 1; take = (a >= b); end
            default: ;
          endcase
        end else if (op == OP_JAL) begin
          take = 1;
        end else if (op == OP_JALR) begin
          take = 1;
          tgt = (rs1 + imm) & ~32'h1;
        end
        if (cnt) mBr = mBr + 1'b1;
        if (take) begin
          if (tgt[1]) nM = 1;
          else begin
            nR = 1; nF = 1; owed = FC - 1; mTarget = tgt; mTaken = mTaken + 1'b1;
          end
        end
      end
    end else if (mRedir) begin
      nF = (owed > 0);
    end else begin
      if (!s) owed--;
      nF = (owed > 0);
    end
    mRedir = nR; mMis = nM; mFlush = nF;
    @(posedge i_clk);
    #1;
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 7'h0, 3'd0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    int flushHigh;
    i_rst = 1; forceX = 0;
    i_valid = 0; i_stall = 0; i_opcode = '0; i_funct3 = '0;
    i_pc = '0; i_imm = '0; i_rs1_data = '0; opA = '0; opB = '0;
    modelReset();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 0;
    #1 checkAll();

    // BEQ taken, flush for FC cycles
    step(1, 0, OP_BRANCH, F3_BEQ, 32'h100, 32'h20, '0, 32'd5, 32'd5);
    check("beq_target", o_target, 32'h120);
    check("beq_redirect", 32'(o_redirect), 32'd1);
    flushHigh = int'(o_flush);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      flushHigh += int'(o_flush);
    end
    check("beq_flush_len", 32'(flushHigh), 32'd2);
    check("beq_br_cnt", 32'(o_br_cnt), 32'd1);

    // BLTU not taken, then BGE taken
    step(1, 0, OP_BRANCH, F3_BLTU, 32'h200, 32'h40, '0, 32'd5, 32'd3);
    step(1, 0, OP_BRANCH, F3_BGE, 32'h200, 32'h40, '0, 32'd5, 32'd3);
    check("bge_target", o_target, 32'h240);
    idle(3);

    // JALR aligned, then misaligned
    step(1, 0, OP_JALR, 3'd0, 32'h300, 32'h1, 32'h2003, '0, '0);
    check("jalr_target", o_target, 32'h2004);
    idle(3);
    step(1, 0, OP_JALR, 3'd0, 32'h300, 32'h1, 32'h2001, '0, '0);
    check("jalr_misalign", 32'(o_misalign), 32'd1);
    idle(1);

    // wrong-path branches during REDIRECT/FLUSH with one stalled flush cycle
    step(1, 0, OP_BRANCH, F3_BNE, 32'h400, 32'h10, '0, 32'd1, 32'd2);
    flushHigh = int'(o_flush);
    step(1, 0, OP_BRANCH, F3_BEQ, 32'h500, 32'h10, '0, 32'd1, 32'd1);
    flushHigh += int'(o_flush);
    step(1, 1, OP_JAL, 3'd0, 32'h600, 32'h10, '0, '0, '0);
    flushHigh += int'(o_flush);
    step(1, 0, OP_JAL, 3'd0, 32'h700, 32'h10, '0, '0, '0);
    flushHigh += int'(o_flush);
    check("squash_flush_len", 32'(flushHigh), 32'd3);
    check("squash_target", o_target, 32'h410);
    idle(2);

    // wrap-around JAL and illegal funct3
    step(1, 0, OP_JAL, 3'd0, 32'hFFFF_FFF0, 32'h20, '0, '0, '0);
    check("jal_wrap", o_target, 32'h10);
    idle(3);
    step(1, 0, OP_BRANCH, 3'b010, 32'h800, 32'h10, '0, 32'd1, 32'd1);

    // unknown comparator flags on a non-branch opcode
    forceX = 1;
    step(1, 0, 7'b0110011, 3'd0, 32'h900, 32'h10, '0, '0, '0);
    forceX = 0;

    // asynchronous reset while flushing
    step(1, 0, OP_JAL, 3'd0, 32'hA00, 32'h10, '0, '0, '0);
    idle(1);
    check("pre_rst_flush", 32'(o_flush), 32'd1);
    #2 i_rst = 1;
    #1;
    check("rst_flush", 32'(o_flush), 32'd0);
    check("rst_redirect", 32'(o_redirect), 32'd0);
    check("rst_br_cnt", 32'(o_br_cnt), 32'd0);
    check("rst_taken_cnt", 32'(o_taken_cnt), 32'd0);
    #1 i_rst = 0;
    modelReset();
    step(1, 0, OP_BRANCH, F3_BLT, 32'hB00, 32'h8, '0, 32'hFFFF_FFFF, 32'd1);
    check("post_rst_target", o_target, 32'hB08);
    idle(3);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] op;
      logic [DW-1:0] imm;
      case ($urandom_range(0, 4))
        0, 1:    op = OP_BRANCH;
        2:       op = OP_JAL;
        3:       op = OP_JALR;
        default: op = 7'($urandom);
      endcase
      imm = $urandom & ~32'h3;
      if ($urandom_range(0, 3) == 0) imm = imm | 32'h2;
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), op, 3'($urandom),
           $urandom & ~32'h3, imm, $urandom, 32'($urandom_range(0, 3)) - 32'd1,
           32'($urandom_range(0, 3)) - 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
